shift_row_pipe: RTL and testbench
=================================

# shift_row_pipe

Parametrised, elastic ShiftRows/InvShiftRows stage for the AES/Rijndael datapath. It supports state widths of 4, 6 or 8 columns (128/192/256-bit Rijndael blocks), selects forward, inverse or bypass per transfer, and carries a sideband tag. It sits between the SubBytes and MixColumns stages of the round pipeline, with valid/ready flow control on both sides and a configurable number of register stages.

## Interface
- NB, 4: state columns; legal values 4, 6, 8. Any other value is an elaboration `$error`.
- STAGES, 2: register slots, 1..4. Any other value is an elaboration `$error`.
- TAG_W, 4: sideband tag width, ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input transfer request
- in_ready  out  1  stage can accept this cycle
- in_data  in  32*NB  state; byte k = bits [8k+7:8k], k = r + 4c (row r, column c)
- in_enc_dec  in  1  1 = forward ShiftRows, 0 = InvShiftRows
- in_bypass  in  1  1 = pass state unpermuted (overrides in_enc_dec)
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output holds a transfer
- out_ready  in  1  downstream accepts
- out_data  out  32*NB  permuted state, same byte layout
- out_tag  out  TAG_W  tag of the transfer on out_data
- occupancy  out  $clog2(STAGES+1)  number of valid slots

## Operation
- Row offsets C1/C2/C3:
  - NB=4: 1/2/3
  - NB=6: 1/2/3
  - NB=8: 1/3/4
  - Row 0 is never shifted.
- Forward: out[r][c] = in[r][(c + Cr) mod NB].
- Inverse: out[r][c] = in[r][(c − Cr + NB) mod NB].
- Bypass: out = in.
- The permutation is combinational on in_data and is captured into slot 0 on accept. Later slots carry data, tag and valid only.
- Transfer semantics:
  - A transfer is accepted when in_valid && in_ready.
  - A transfer is delivered when out_valid && out_ready.
- Elastic pipeline of STAGES slots, each with its own valid bit:
  - Slot i advances into slot i+1 when slot i+1 is empty or slot i+1 itself advances.
  - The last slot drains on out_ready.
  - in_ready = !valid[0] || slot 0 advances. The ready path is a combinational chain from out_ready.
- No bubbles are inserted. Order is strictly preserved. Transfers are never dropped or duplicated.
- occupancy equals the count of set valid bits. It changes by +1, −1 or 0 per cycle; 0 on simultaneous accept and deliver.
- Per-transfer mode: in_enc_dec and in_bypass are sampled only at accept. Mixed modes back-to-back are legal.

## Timing
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert handled upstream):
  - all valid bits = 0, out_valid = 0, out_data = 0, out_tag = 0, occupancy = 0
  - in_ready = 1 from the first cycle after reset.
- Latency: accept at edge n gives out_valid = 1 after edge n+STAGES−1, i.e. visible STAGES cycles after in_valid is presented, when unstalled.
- Throughput: one transfer per cycle with out_ready held high.
- Stall behaviour: while out_valid && !out_ready, out_data and out_tag are stable. The pipe fills to STAGES entries, then in_ready = 0.
- Full with simultaneous out_ready = 1: in_ready = 1 in the same cycle, and accept and deliver both occur.
- Empty with in_valid = 0: out_valid = 0 and no state changes.
- Reset asserted mid-stream: all in-flight transfers are discarded immediately, and outputs return to reset values without waiting for clk.
- in_valid may drop without a transfer. A held request need not keep in_data stable.

## Test plan
- NB=4, forward, FIPS-197 App. B round 1:
  - in_data bytes 0..15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30
  - required out bytes = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, after exactly STAGES cycles.
- Same NB=4 vector, inverse mode on that output → original SubBytes bytes returned. Bypass mode → input unchanged.
- NB=8, forward, in byte k = k (0x00..0x1F):
  - out byte 1 = 0x05, byte 2 = 0x0E, byte 3 = 0x13, byte 0 = 0x00.
  - Inverse of the result restores k for all 32 bytes.
- STAGES=3, 10 back-to-back transfers with tags 0..9 and alternating modes; out_ready low for cycles 4–8:
  - occupancy reaches 3, then in_ready = 0.
  - out_data is stable during the stall.
  - All 10 transfers are delivered in tag order with the correct per-transfer mode.
  - Zero bubbles when out_ready is high.
- Full pipe with in_valid = 1 and out_ready = 1 held: one accept and one deliver per cycle; occupancy stays at STAGES.
- Random traffic of 2 in-flight transfers, then rst_n pulsed low between edges:
  - out_valid, occupancy, out_data and out_tag go to 0 asynchronously.
  - After release, the first new transfer appears with latency STAGES.
  - No stale data is delivered.

Source files
------------

// File: rtl/shift_row_pipe.sv
// shift_row_pipe: elastic ShiftRows/InvShiftRows/bypass stage for 4/6/8-column Rijndael
// states, with a tag sideband and a STAGES-deep valid/ready register pipeline.
module shift_row_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [32*NB-1:0]             in_data,
    input  logic                         in_enc_dec,
    input  logic                         in_bypass,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [32*NB-1:0]             out_data,
    output logic [TAG_W-1:0]             out_tag,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);
    localparam int W  = 32 * NB;
    localparam int OW = $clog2(STAGES + 1);

    generate
        if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
            $error("shift_row_pipe: NB must be 4, 6 or 8");
        end
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("shift_row_pipe: STAGES must be 1..4");
        end
    endgenerate

    logic [W-1:0]     perm;
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] adv;
    logic             full;
    logic             accept;
    logic [W-1:0]     data [STAGES];
    logic [TAG_W-1:0] tag  [STAGES];

    function automatic int row_shift(input int r);
        return (r == 0) ? 0 : (r == 1) ? 1 : (NB == 8) ? r + 1 : r;
    endfunction

    always_comb begin
        perm = in_data;
        for (int r = 1; r < 4; r++)
            for (int c = 0; c < NB; c++)
                if (!in_bypass)
                    perm[8*(r+4*c) +: 8] = in_data[8*(r + 4*(in_enc_dec ? (c + row_shift(r)) % NB
                                                                        : (c - row_shift(r) + NB) % NB)) +: 8];
    end

    // A slot moves whenever any slot downstream of it is empty or the tail drains,
    // which flattens the ready chain into a per-slot expression.
    always_comb begin
        full = 1'b1;
        adv  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i] = valid[i] && (out_ready || !full);
            full   = full && valid[i];
        end
    end

    assign in_ready = !valid[0] || adv[0];
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data[i] <= '0;
                tag[i]  <= '0;
            end
        end else begin
            if (accept) begin
                data[0] <= perm;
                tag[0]  <= in_tag;
            end
            valid[0] <= accept || (valid[0] && !adv[0]);
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i-1]) begin
                    data[i] <= data[i-1];
                    tag[i]  <= tag[i-1];
                end
                valid[i] <= adv[i-1] || (valid[i] && !adv[i]);
            end
        end
    end

    assign out_valid = valid[STAGES-1];
    assign out_data  = data[STAGES-1];
    assign out_tag   = tag[STAGES-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++)
            occupancy = occupancy + OW'(valid[i]);
    end
endmodule

// File: tb/tb_shift_row_pipe.sv
// tb_shift_row_pipe: randomized and directed checks of shift_row_pipe against a
// row-rotation reference model and a transfer scoreboard.
module tb_shift_row_pipe;
    localparam int S  = 3;
    localparam int SB = 2;
    localparam logic [127:0] FIPS_IN  = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
    localparam logic [127:0] FIPS_OUT = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_in_valid = 1'b0, a_in_enc_dec = 1'b1, a_in_bypass = 1'b0, a_out_ready = 1'b1;
    logic         a_in_ready, a_out_valid;
    logic [127:0] a_in_data = '0, a_out_data;
    logic [3:0]   a_in_tag = '0, a_out_tag;
    logic [1:0]   a_occupancy;

    logic         b_in_valid = 1'b0, b_in_enc_dec = 1'b1, b_in_bypass = 1'b0, b_out_ready = 1'b1;
    logic         b_in_ready, b_out_valid;
    logic [255:0] b_in_data = '0, b_out_data;
    logic [3:0]   b_in_tag = '0, b_out_tag;
    logic [1:0]   b_occupancy;

    shift_row_pipe #(.NB(4), .STAGES(S), .TAG_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_enc_dec(a_in_enc_dec), .in_bypass(a_in_bypass),
        .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_tag(a_out_tag), .occupancy(a_occupancy));

    shift_row_pipe #(.NB(8), .STAGES(SB), .TAG_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_enc_dec(b_in_enc_dec), .in_bypass(b_in_bypass),
        .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_tag(b_out_tag), .occupancy(b_occupancy));

    int checks = 0;
    int failures = 0;
    int delivered = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: view the state as a 4 x nb byte matrix and rotate each row left
    // (forward) or right (inverse) by its Rijndael offset.
    function automatic logic [255:0] ref_perm(input logic [255:0] d, input int nb,
                                              input logic enc, input logic byp);
        logic [7:0] m [4][8];
        logic [7:0] o [4][8];
        int offs [4];
        logic [255:0] res;
        if (byp) return d;
        if (nb == 8) offs = '{0, 1, 3, 4};
        else         offs = '{0, 1, 2, 3};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++)
                m[r][c] = d[8*(r+4*c) +: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++)
                if (enc) o[r][c] = m[r][(c + offs[r]) % nb];
                else     o[r][(c + offs[r]) % nb] = m[r][c];
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++)
                res[8*(r+4*c) +: 8] = o[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    typedef struct {
        logic [127:0] d;
        logic [3:0]   t;
        int           acc;
    } item_t;
    item_t q[$];

    // Scoreboard: every negedge, occupancy, in_ready, out_valid timing, stall hold
    // and delivered content are compared with the queue of accepted transfers.
    initial begin
        int mcyc = 0;
        logic pstall = 1'b0;
        logic [131:0] pdata = '0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (!rst_n) begin
                q.delete();
                pstall = 1'b0;
            end else begin
                check("occupancy", 256'(a_occupancy), 256'(q.size()));
                check("in_ready", 256'(a_in_ready), 256'(q.size() < S || a_out_ready));
                check("out_valid", 256'(a_out_valid), 256'(q.size() > 0 && q[0].acc + S <= mcyc));
                if (pstall) check("stall_hold", 256'({a_out_tag, a_out_data}), 256'(pdata));
                pstall = a_out_valid && !a_out_ready;
                pdata  = {a_out_tag, a_out_data};
                if (a_out_valid && a_out_ready && q.size() > 0) begin
                    check("deliver_data", 256'(a_out_data), 256'(q[0].d));
                    check("deliver_tag", 256'(a_out_tag), 256'(q[0].t));
                    void'(q.pop_front());
                    delivered++;
                end
                if (a_in_valid && a_in_ready)
                    q.push_back('{d: ref_perm(256'(a_in_data), 4, a_in_enc_dec, a_in_bypass)
                                     [127:0], t: a_in_tag, acc: mcyc});
            end
        end
    end

    task automatic tick(output logic acc);
        @(negedge clk);
        acc = a_in_valid && a_in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [127:0] d, input logic enc, input logic byp, input logic [3:0] t,
                          output logic [127:0] od, output logic [3:0] ot, output int lat);
        a_in_valid = 1'b1; a_in_data = d; a_in_enc_dec = enc; a_in_bypass = byp; a_in_tag = t;
        a_out_ready = 1'b1;
        lat = -1; od = '0; ot = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            a_in_valid = 1'b0;
            if (a_out_valid) begin
                lat = i; od = a_out_data; ot = a_out_tag;
                break;
            end
        end
    endtask

    task automatic send_b(input logic [255:0] d, input logic enc, input logic byp,
                          output logic [255:0] od, output int lat);
        b_in_valid = 1'b1; b_in_data = d; b_in_enc_dec = enc; b_in_bypass = byp; b_in_tag = 4'h5;
        lat = -1; od = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            b_in_valid = 1'b0;
            if (b_out_valid) begin
                lat = i; od = b_out_data;
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [127:0] od, od2;
        logic [3:0]   ot;
        logic [255:0] d8, ob, ob2;
        int lat, sent, base, occ_max;
        logic acc, blocked;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(a_out_valid), 256'(0));
        check("rst_occupancy", 256'(a_occupancy), 256'(0));
        check("rst_out_data", 256'(a_out_data), 256'(0));
        check("rst_out_tag", 256'(a_out_tag), 256'(0));
        check("rst_b_out_valid", 256'(b_out_valid), 256'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 256'(a_in_ready), 256'(1));

        send_a(FIPS_IN, 1'b1, 1'b0, 4'h1, od, ot, lat);
        check("fips_fwd_latency", 256'(lat), 256'(S));
        check("fips_fwd_data", 256'(od), 256'(FIPS_OUT));
        check("fips_fwd_tag", 256'(ot), 256'(4'h1));
        send_a(od, 1'b0, 1'b0, 4'h2, od2, ot, lat);
        check("fips_inv_data", 256'(od2), 256'(FIPS_IN));
        check("fips_inv_latency", 256'(lat), 256'(S));
        send_a(FIPS_IN, 1'b0, 1'b1, 4'h3, od2, ot, lat);
        check("fips_bypass_data", 256'(od2), 256'(FIPS_IN));

        for (int k = 0; k < 32; k++) d8[8*k +: 8] = 8'(k);
        send_b(d8, 1'b1, 1'b0, ob, lat);
        check("nb8_latency", 256'(lat), 256'(SB));
        check("nb8_byte0", 256'(ob[7:0]), 256'(8'h00));
        check("nb8_byte1", 256'(ob[15:8]), 256'(8'h05));
        check("nb8_byte2", 256'(ob[23:16]), 256'(8'h0e));
        check("nb8_byte3", 256'(ob[31:24]), 256'(8'h13));
        check("nb8_fwd_model", ob, ref_perm(d8, 8, 1'b1, 1'b0));
        send_b(ob, 1'b0, 1'b0, ob2, lat);
        check("nb8_inv_restore", ob2, d8);

        // Ten back-to-back transfers with a five-cycle downstream stall.
        @(posedge clk);
        #1;
        base = delivered; sent = 0; occ_max = 0; blocked = 1'b0;
        for (int c = 0; c < 80 && delivered - base < 10; c++) begin
            a_out_ready  = !(c >= 4 && c <= 8);
            a_in_valid   = sent < 10;
            a_in_data    = rnd128();
            a_in_tag     = 4'(sent);
            a_in_enc_dec = sent[0];
            a_in_bypass  = (sent % 3) == 2;
            #1;
            if (a_occupancy > occ_max) occ_max = a_occupancy;
            if (a_occupancy == 2'(S) && !a_in_ready) blocked = 1'b1;
            tick(acc);
            if (acc) sent++;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        check("stall_delivered", 256'(delivered - base), 256'(10));
        check("stall_occ_max", 256'(occ_max), 256'(S));
        check("stall_in_ready_low", 256'(blocked), 256'(1));

        // Fill, then hold in_valid and out_ready high.
        a_in_valid = 1'b1; a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_data = rnd128(); a_in_tag = 4'($urandom()); a_in_enc_dec = 1'($urandom());
            tick(acc);
        end
        a_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_in_data = rnd128(); a_in_tag = 4'($urandom()); a_in_enc_dec = 1'($urandom());
            a_in_bypass = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            check("tput_occ", 256'(a_occupancy), 256'(S));
            check("tput_in_ready", 256'(a_in_ready), 256'(1));
            check("tput_out_valid", 256'(a_out_valid), 256'(1));
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;

        for (int i = 0; i < 300; i++) begin
            a_in_valid   = $urandom_range(0, 9) < 7;
            a_out_ready  = $urandom_range(0, 9) < 6;
            a_in_data    = rnd128();
            a_in_tag     = 4'($urandom());
            a_in_enc_dec = 1'($urandom());
            a_in_bypass  = $urandom_range(0, 3) == 0;
            tick(acc);
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (8) tick(acc);
        check("drain_empty", 256'(a_occupancy), 256'(0));

        // Two transfers in flight, then an asynchronous reset pulse between edges.
        a_in_valid = 1'b1; a_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_in_data = rnd128(); a_in_tag = 4'(i + 7); a_in_enc_dec = 1'b1; a_in_bypass = 1'b0;
            tick(acc);
        end
        a_in_valid = 1'b0;
        check("pre_rst_occ", 256'(a_occupancy), 256'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 256'(a_out_valid), 256'(0));
        check("async_rst_occ", 256'(a_occupancy), 256'(0));
        check("async_rst_data", 256'(a_out_data), 256'(0));
        check("async_rst_tag", 256'(a_out_tag), 256'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        od2 = rnd128();
        send_a(od2, 1'b1, 1'b0, 4'hc, od, ot, lat);
        check("post_rst_latency", 256'(lat), 256'(S));
        check("post_rst_data", 256'(od), ref_perm(256'(od2), 4, 1'b1, 1'b0));
        check("post_rst_tag", 256'(ot), 256'(4'hc));
        repeat (4) tick(acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
